uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Sequencer in front of uart_tx: generates its baud clock-enable, buffers outgoing characters in a small FIFO, and issues one start handshake per character.
- Bus-side logic writes 9-bit characters. The controller pops them one at a time and drives uart_tx i_data/i_start, waiting on o_busy between frames.
- Frame format (length, stop2, parity, odd) is wired to uart_tx directly and is not handled here.

Parameters:
- FIFO_DEPTH, 8, FIFO entries; power of two, minimum 2.
- DIV_W, 16, width of baud divider.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of o_level (derived, not overridden).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_div  in  DIV_W  baud divider; o_ce pulses once every i_div+1 clocks
- i_wr  in  1  FIFO write strobe
- i_wdata  in  9  character to enqueue
- o_full  out  1  FIFO full
- o_empty  out  1  FIFO empty
- o_level  out  LVL_W  FIFO occupancy, 0..FIFO_DEPTH
- o_overflow  out  1  sticky: a write was dropped
- o_idle  out  1  FIFO empty, FSM in IDLE, i_busy low
- o_ce  out  1  to uart_tx i_ce
- o_data  out  9  to uart_tx i_data
- o_start  out  1  to uart_tx i_start
- i_busy  in  1  from uart_tx o_busy

Behaviour:
- Reset (i_rst high at a clock edge): o_ce=0, o_start=0, o_data=0, o_overflow=0. FIFO flushed (o_empty=1, o_full=0, o_level=0). Baud counter=0. FSM=IDLE. o_idle follows its definition.
- Reset mid-frame or mid-handshake aborts everything. Queued data is lost. uart_tx shares i_rst.

Baud divider:
- Registered counter cnt[DIV_W-1:0].
- Each non-reset cycle: if cnt>=i_div, then cnt<=0 and o_ce<=1; else cnt<=cnt+1 and o_ce<=0.
- i_div=0: o_ce=1 every cycle, starting the first cycle after reset.
- i_div=3: o_ce high for 1 cycle in 4. First pulse is 4 clocks after reset release.
- Lowering i_div below the current cnt takes effect on the next edge; no wrap through 2^DIV_W.
- The divider free-runs and is independent of FSM state.

FIFO:
- Circular buffer with read/write pointers one bit wider than the index.
- Write accepted when i_wr=1 and o_full=0 (registered value).
- Write with o_full=1 is dropped and sets o_overflow, even if a pop occurs in the same cycle.
- Simultaneous accepted write and pop: o_level unchanged.
- Flags and o_level are registered, updated the cycle after the event.

FSM (IDLE, START, WAIT):
- IDLE: if o_empty=0 and i_busy=0, pop head into o_data, set o_start<=1, go START. Otherwise stay.
- START: o_start and o_data held stable. When i_busy=1, set o_start<=0 and go WAIT. No timeout; START persists until uart_tx accepts.
- WAIT: when i_busy=0, go IDLE.
- o_data keeps the last popped value until the next pop.
- Latency:
  - Write at cycle N into an empty FIFO, uart_tx idle: o_start=1 at N+2.
  - o_start drops the cycle after busy is first seen high.
  - Next frame's o_start rises ≥2 cycles after busy falls.
- o_start is never high while the FSM is in WAIT or IDLE.
- o_idle is combinational from registered state.

Test Plan:
- i_div=3, no writes, 40 clocks after reset -> exactly 10 o_ce pulses, each 1 cycle wide, 4 cycles apart; o_idle=1 throughout.
- i_div=0, write 9'h069, uart_tx model with 2-cycle busy latency -> o_data=9'h069, o_start high from write+2 until busy seen; one frame sent; o_idle returns to 1.
- Write 3 chars (9'h001, 9'h0AA, 9'h1FF) back-to-back -> o_level goes 1,2,3 then decrements per pop; o_data takes the values in order; a new o_start appears only after busy falls.
- Write FIFO_DEPTH+1 chars while busy is held high -> o_full=1, o_level=8, 9th write dropped, o_overflow=1 and stays 1 after the FIFO drains.
- Full FIFO plus simultaneous write and pop -> write dropped, o_level becomes 7, o_overflow=1.
- Assert i_rst while in START with 4 chars queued -> next cycle o_start=0, o_empty=1, o_level=0, o_overflow=0, FSM IDLE, no further start pulses.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//
// Sequencer that sits in front of a uart_tx transmitter. It does three jobs:
//   1. Generates the baud clock-enable (o_ce) from a programmable divider.
//   2. Buffers 9-bit characters written by the bus side in a small FIFO.
//   3. Pops one character at a time and performs a start handshake with
//      uart_tx: raise o_start with o_data stable, wait for busy to go high,
//      drop o_start, then wait for busy to fall before the next character.
//
// Frame format (length, stop bits, parity) is wired straight to uart_tx and
// is not handled here.
//
// Parameters:
//   FIFO_DEPTH  FIFO entries; must be a power of two, at least 2
//   DIV_W       width of the baud divider
//   LVL_W       width of o_level (derived, 0..FIFO_DEPTH must fit)
//
// Ports:
//   i_clk       clock
//   i_rst       synchronous active-high reset (shared with uart_tx)
//   i_div       baud divider; o_ce pulses once every i_div+1 clocks
//   i_wr        FIFO write strobe
//   i_wdata     character to enqueue
//   o_full      FIFO full (registered)
//   o_empty     FIFO empty (registered)
//   o_level     FIFO occupancy 0..FIFO_DEPTH (registered)
//   o_overflow  sticky flag: a write was dropped because the FIFO was full
//   o_idle      FIFO empty, sequencer idle and uart_tx not busy
//   o_ce        baud clock-enable to uart_tx i_ce
//   o_data      character to uart_tx i_data
//   o_start     start request to uart_tx i_start
//   i_busy      busy indication from uart_tx o_busy
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
   parameter  int FIFO_DEPTH = 8,
   parameter  int DIV_W      = 16,
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [DIV_W-1:0] i_div,
   input  logic             i_wr,
   input  logic [8:0]       i_wdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [LVL_W-1:0] o_level,
   output logic             o_overflow,
   output logic             o_idle,
   output logic             o_ce,
   output logic [8:0]       o_data,
   output logic             o_start,
   input  logic             i_busy
);

   // Index width of the storage array; pointers carry one extra wrap bit.
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Baud divider state
   // ------------------------------------------------------------------
   logic [DIV_W-1:0] cnt_r;
   logic             ce_r;

   // ------------------------------------------------------------------
   // FIFO state
   // ------------------------------------------------------------------
   logic [8:0]       mem_r [FIFO_DEPTH];
   logic [AW:0]      wptr_r;
   logic [AW:0]      rptr_r;
   logic [LVL_W-1:0] level_r;
   logic [LVL_W-1:0] level_nxt_s;
   logic             full_r;
   logic             empty_r;
   logic             ovf_r;
   logic             wr_acc_s;
   logic [8:0]       head_s;

   // ------------------------------------------------------------------
   // Sequencer state
   // ------------------------------------------------------------------
   state_t           state_r;
   state_t           state_nxt_s;
   logic             pop_s;
   logic             start_r;
   logic             start_nxt_s;
   logic [8:0]       data_r;
   logic [8:0]       data_nxt_s;

   // Baud divider: count up to i_div, then wrap to zero with a one-cycle
   // enable pulse. The >= compare means lowering i_div below the current
   // count wraps on the very next edge instead of running through 2^DIV_W.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_r <= {DIV_W{1'b0}};
         ce_r  <= 1'b0;
      end else if (cnt_r >= i_div) begin
         cnt_r <= {DIV_W{1'b0}};
         ce_r  <= 1'b1;
      end else begin
         cnt_r <= cnt_r + DIV_W'(1);
         ce_r  <= 1'b0;
      end
   end

   // FIFO write acceptance and next occupancy. The full flag used here is
   // the registered one, so a write arriving while full is dropped even if
   // the sequencer frees a slot in the same cycle.
   always_comb begin
      wr_acc_s    = i_wr & ~full_r;
      level_nxt_s = level_r;
      if (wr_acc_s && !pop_s) begin
         level_nxt_s = level_r + LVL_W'(1);
      end else if (!wr_acc_s && pop_s) begin
         level_nxt_s = level_r - LVL_W'(1);
      end else begin
         level_nxt_s = level_r;
      end
   end

   // Head of the FIFO, presented to the sequencer for popping.
   assign head_s = mem_r[rptr_r[AW-1:0]];

   // FIFO pointers, occupancy and flags. Flags are derived from the next
   // occupancy so they appear one cycle after the event, together with
   // o_level. Overflow is sticky until reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wptr_r  <= {(AW+1){1'b0}};
         rptr_r  <= {(AW+1){1'b0}};
         level_r <= {LVL_W{1'b0}};
         full_r  <= 1'b0;
         empty_r <= 1'b1;
         ovf_r   <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wptr_r <= wptr_r + (AW+1)'(1);
         end
         if (pop_s) begin
            rptr_r <= rptr_r + (AW+1)'(1);
         end
         level_r <= level_nxt_s;
         full_r  <= (level_nxt_s == LVL_W'(FIFO_DEPTH));
         empty_r <= (level_nxt_s == {LVL_W{1'b0}});
         if (i_wr && full_r) begin
            ovf_r <= 1'b1;
         end
      end
   end

   // FIFO storage. Not reset: reset flushes the FIFO through the pointers,
   // so stale contents are never observable.
   always_ff @(posedge i_clk) begin
      if (wr_acc_s) begin
         mem_r[wptr_r[AW-1:0]] <= i_wdata;
      end
   end

   // Sequencer state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Sequencer next-state logic. START has no timeout: it waits for
   // uart_tx to acknowledge by raising busy, however long that takes.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!empty_r && !i_busy) begin
               state_nxt_s = ST_START;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (i_busy) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_START;
            end
         end
         ST_WAIT: begin
            if (!i_busy) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Sequencer output logic: decides when to pop and what o_start/o_data
   // become on the next edge. o_data only changes on a pop, so it keeps
   // the last character sent between frames.
   always_comb begin
      pop_s       = 1'b0;
      start_nxt_s = 1'b0;
      data_nxt_s  = data_r;
      case (state_r)
         ST_IDLE: begin
            if (!empty_r && !i_busy) begin
               pop_s       = 1'b1;
               start_nxt_s = 1'b1;
               data_nxt_s  = head_s;
            end else begin
               pop_s       = 1'b0;
               start_nxt_s = 1'b0;
            end
         end
         ST_START: begin
            if (i_busy) begin
               start_nxt_s = 1'b0;
            end else begin
               start_nxt_s = 1'b1;
            end
         end
         ST_WAIT: begin
            start_nxt_s = 1'b0;
         end
         default: begin
            start_nxt_s = 1'b0;
         end
      endcase
   end

   // Registered handshake outputs towards uart_tx.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         start_r <= 1'b0;
         data_r  <= 9'h000;
      end else begin
         start_r <= start_nxt_s;
         data_r  <= data_nxt_s;
      end
   end

   assign o_full     = full_r;
   assign o_empty    = empty_r;
   assign o_level    = level_r;
   assign o_overflow = ovf_r;
   assign o_ce       = ce_r;
   assign o_data     = data_r;
   assign o_start    = start_r;
   // Idle is built from registered state plus the live busy input.
   assign o_idle     = empty_r & (state_r == ST_IDLE) & ~i_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for uart_tx_ctrl. A small uart_tx model answers the
// start handshake (busy two cycles after start, held for FRAME cycles) and a
// monitor records every character issued on a rising o_start. Expected
// characters are queued when written and compared against the monitor record.
// -----------------------------------------------------------------------------
module tb_uart_tx_ctrl;

   localparam int DEPTH = 8;
   localparam int DIV_W = 16;
   localparam int LVL_W = 4;
   localparam int FRAME = 6;

   logic             clk   = 1'b0;
   logic             rst   = 1'b1;
   logic [DIV_W-1:0] div   = 16'd3;
   logic             wr    = 1'b0;
   logic [8:0]       wdata = 9'h000;
   logic             busy  = 1'b0;
   logic             o_full, o_empty, o_overflow, o_idle, o_ce, o_start;
   logic [LVL_W-1:0] o_level;
   logic [8:0]       o_data;

   uart_tx_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
      .i_clk(clk), .i_rst(rst), .i_div(div), .i_wr(wr), .i_wdata(wdata),
      .o_full(o_full), .o_empty(o_empty), .o_level(o_level),
      .o_overflow(o_overflow), .o_idle(o_idle), .o_ce(o_ce),
      .o_data(o_data), .o_start(o_start), .i_busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [8:0] exp_q [$];
   logic [8:0] obs_mem [256];
   int         obs_wr = 0;
   int         obs_rd = 0;

   int   start_rises = 0;
   int   bad_gap     = 0;
   int   bad_start   = 0;
   int   cyc         = 0;
   int   last_fall   = -100;
   logic hold_busy   = 1'b0;
   int   pend        = 0;
   int   bcnt        = 0;
   logic prev_start  = 1'b0;

   // Monitor plus uart_tx model, evaluated on the falling edge.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (o_start && !prev_start) begin
         obs_mem[obs_wr[7:0]] = o_data;
         obs_wr = obs_wr + 1;
         start_rises = start_rises + 1;
         if (busy || pend > 0) bad_start = bad_start + 1;
         if (cyc - last_fall < 2) bad_gap = bad_gap + 1;
      end
      prev_start = o_start;
      if (rst) begin
         busy = 1'b0; pend = 0; bcnt = 0;
      end else if (hold_busy) begin
         busy = 1'b1;
      end else if (busy) begin
         if (bcnt <= 1) begin
            if (bcnt == 1) last_fall = cyc;
            busy = 1'b0; bcnt = 0;
         end else begin
            bcnt = bcnt - 1;
         end
      end else if (pend > 0) begin
         pend = pend - 1;
         if (pend == 0) begin busy = 1'b1; bcnt = FRAME; end
      end else if (o_start) begin
         pend = 2;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wr_char(input logic [8:0] d, input bit acc);
      wr = 1'b1; wdata = d;
      if (acc) exp_q.push_back(d);
      step();
      wr = 1'b0;
   endtask

   // Holds reset over two edges and leaves it asserted for the caller.
   task automatic do_reset();
      rst = 1'b1; hold_busy = 1'b0; exp_q.delete();
      step(); step();
      obs_rd = obs_wr;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 600; k++) begin
         step();
         if (o_idle === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   // Scoreboard drain: every queued character must have been issued, in order.
   task automatic check_sb(input string name);
      logic [8:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs_rd >= obs_wr) begin
            n_fail++; $display("FAIL %s_missing: no character issued, expected %h", name, e);
         end else begin
            if (obs_mem[obs_rd[7:0]] !== e) begin
               n_fail++; $display("FAIL %s_data: got %h expected %h", name, obs_mem[obs_rd[7:0]], e);
            end
            obs_rd++;
         end
      end
      n_checks++;
      if (obs_rd != obs_wr) begin
         n_fail++; $display("FAIL %s_extra: %0d extra characters issued, expected 0", name, obs_wr - obs_rd);
      end
      obs_rd = obs_wr;
   endtask

   task automatic test_reset();
      div = 16'd3;
      do_reset();
      n_checks++; if (o_ce !== 1'b0)       begin n_fail++; $display("FAIL reset_ce: got %b expected 0", o_ce); end
      n_checks++; if (o_start !== 1'b0)    begin n_fail++; $display("FAIL reset_start: got %b expected 0", o_start); end
      n_checks++; if (o_data !== 9'h000)   begin n_fail++; $display("FAIL reset_data: got %h expected 000", o_data); end
      n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", o_overflow); end
      n_checks++; if (o_empty !== 1'b1)    begin n_fail++; $display("FAIL reset_empty: got %b expected 1", o_empty); end
      n_checks++; if (o_full !== 1'b0)     begin n_fail++; $display("FAIL reset_full: got %b expected 0", o_full); end
      n_checks++; if (o_level !== 4'd0)    begin n_fail++; $display("FAIL reset_level: got %0d expected 0", o_level); end
      n_checks++; if (o_idle !== 1'b1)     begin n_fail++; $display("FAIL reset_idle: got %b expected 1", o_idle); end
      rst = 1'b0;
   endtask

   // Runs straight after test_reset releases reset with i_div=3.
   task automatic test_baud();
      int pulses = 0, first = -1, last = -1, bad_space = 0, not_idle = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (o_ce === 1'b1) begin
            pulses++;
            if (first < 0) first = i;
            else if (i - last != 4) bad_space++;
            last = i;
         end
         if (o_idle !== 1'b1) not_idle++;
      end
      n_checks++; if (pulses != 10)   begin n_fail++; $display("FAIL baud_pulses: got %0d expected 10", pulses); end
      n_checks++; if (first != 4)     begin n_fail++; $display("FAIL baud_first: got %0d expected 4", first); end
      n_checks++; if (bad_space != 0) begin n_fail++; $display("FAIL baud_spacing: got %0d bad gaps expected 0", bad_space); end
      n_checks++; if (not_idle != 0)  begin n_fail++; $display("FAIL baud_idle: got %0d non-idle cycles expected 0", not_idle); end
   endtask

   task automatic test_div_edges();
      int ce_hi = 0;
      div = 16'd0;
      do_reset(); rst = 1'b0;
      for (int i = 0; i < 5; i++) begin step(); if (o_ce === 1'b1) ce_hi++; end
      n_checks++; if (ce_hi != 5) begin n_fail++; $display("FAIL div0_ce: got %0d pulses in 5 cycles expected 5", ce_hi); end
      div = 16'd10;
      do_reset(); rst = 1'b0;
      ce_hi = 0;
      for (int i = 0; i < 8; i++) begin step(); if (o_ce === 1'b1) ce_hi++; end
      n_checks++; if (ce_hi != 0) begin n_fail++; $display("FAIL div10_ce: got %0d pulses expected 0", ce_hi); end
      div = 16'd3;
      step();
      n_checks++; if (o_ce !== 1'b1) begin n_fail++; $display("FAIL div_lower_ce: got %b expected 1", o_ce); end
      step();
      n_checks++; if (o_ce !== 1'b0) begin n_fail++; $display("FAIL div_lower_next: got %b expected 0", o_ce); end
   endtask

   task automatic test_single();
      int base, hi;
      bit seen, ok;
      div = 16'd0;
      do_reset(); rst = 1'b0;
      base = start_rises;
      wr_char(9'h069, 1'b1);
      n_checks++; if (o_start !== 1'b0) begin n_fail++; $display("FAIL single_start_n1: got %b expected 0", o_start); end
      step();
      n_checks++; if (o_start !== 1'b1)  begin n_fail++; $display("FAIL single_start_n2: got %b expected 1", o_start); end
      n_checks++; if (o_data !== 9'h069) begin n_fail++; $display("FAIL single_data: got %h expected 069", o_data); end
      hi = 1; seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (busy === 1'b1) begin
            seen = 1'b1;
            n_checks++; if (o_start !== 1'b0) begin n_fail++; $display("FAIL single_start_drop: got %b expected 0", o_start); end
            break;
         end
         if (o_start === 1'b1) hi++;
      end
      n_checks++; if (!seen)   begin n_fail++; $display("FAIL single_busy: got no busy expected busy within 20 cycles"); end
      n_checks++; if (hi != 3) begin n_fail++; $display("FAIL single_start_len: got %0d cycles expected 3", hi); end
      wait_idle(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL single_idle: got o_idle=%b expected 1", o_idle); end
      check_sb("single");
      n_checks++; if (start_rises - base != 1) begin n_fail++; $display("FAIL single_frames: got %0d expected 1", start_rises - base); end
   endtask

   task automatic test_back_to_back();
      int base, gap0, prev, bad_dec;
      bit ok;
      logic [8:0] chars [3];
      chars[0] = 9'h001; chars[1] = 9'h0AA; chars[2] = 9'h1FF;
      hold_busy = 1'b1; step();
      base = start_rises; gap0 = bad_gap;
      for (int i = 0; i < 3; i++) begin
         wr_char(chars[i], 1'b1);
         n_checks++;
         if (o_level !== LVL_W'(i + 1)) begin n_fail++; $display("FAIL b2b_level_up: got %0d expected %0d", o_level, i + 1); end
      end
      hold_busy = 1'b0;
      prev = 3; bad_dec = 0; ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         step();
         if (int'(o_level) != prev) begin
            if (int'(o_level) != prev - 1) bad_dec++;
            prev = int'(o_level);
         end
         if (o_idle === 1'b1) begin ok = 1'b1; break; end
      end
      n_checks++; if (!ok)          begin n_fail++; $display("FAIL b2b_idle: got o_idle=%b expected 1", o_idle); end
      n_checks++; if (bad_dec != 0) begin n_fail++; $display("FAIL b2b_level_down: got %0d bad steps expected 0", bad_dec); end
      n_checks++; if (o_level !== 4'd0) begin n_fail++; $display("FAIL b2b_level_end: got %0d expected 0", o_level); end
      check_sb("b2b");
      n_checks++; if (start_rises - base != 3) begin n_fail++; $display("FAIL b2b_frames: got %0d expected 3", start_rises - base); end
      n_checks++; if (bad_gap - gap0 != 0) begin n_fail++; $display("FAIL b2b_gap: got %0d early starts expected 0", bad_gap - gap0); end
      n_checks++; if (bad_start != 0)      begin n_fail++; $display("FAIL b2b_busy_start: got %0d starts while busy expected 0", bad_start); end
   endtask

   task automatic test_overflow();
      bit ok;
      do_reset(); rst = 1'b0;
      hold_busy = 1'b1; step();
      for (int i = 0; i < DEPTH + 1; i++) begin
         wr_char(9'(i * 37 + 5), i < DEPTH);
         if (i == DEPTH - 1) begin
            n_checks++; if (o_full !== 1'b1)     begin n_fail++; $display("FAIL ovf_full: got %b expected 1", o_full); end
            n_checks++; if (o_level !== 4'd8)    begin n_fail++; $display("FAIL ovf_level8: got %0d expected 8", o_level); end
            n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", o_overflow); end
         end
      end
      n_checks++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", o_overflow); end
      n_checks++; if (o_level !== 4'd8)    begin n_fail++; $display("FAIL ovf_level_keep: got %0d expected 8", o_level); end
      hold_busy = 1'b0;
      wait_idle(ok);
      n_checks++; if (!ok)                 begin n_fail++; $display("FAIL ovf_idle: got o_idle=%b expected 1", o_idle); end
      n_checks++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", o_overflow); end
      n_checks++; if (o_empty !== 1'b1)    begin n_fail++; $display("FAIL ovf_drained: got %b expected 1", o_empty); end
      check_sb("ovf");
   endtask

   task automatic test_full_wr_pop();
      bit ok;
      do_reset(); rst = 1'b0;
      hold_busy = 1'b1; step();
      for (int i = 0; i < DEPTH; i++) wr_char(9'(i * 11 + 3), 1'b1);
      hold_busy = 1'b0;
      wr = 1'b1; wdata = 9'h155;
      step();
      wr = 1'b0;
      n_checks++; if (o_level !== 4'd7)    begin n_fail++; $display("FAIL fwp_level: got %0d expected 7", o_level); end
      n_checks++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL fwp_ovf: got %b expected 1", o_overflow); end
      n_checks++; if (o_full !== 1'b0)     begin n_fail++; $display("FAIL fwp_full: got %b expected 0", o_full); end
      wait_idle(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL fwp_idle: got o_idle=%b expected 1", o_idle); end
      check_sb("fwp");
   endtask

   // Entered with o_overflow still set by the previous scenario.
   task automatic test_reset_mid();
      int base, hi;
      logic [8:0] e0;
      hold_busy = 1'b1; step();
      for (int i = 0; i < 5; i++) wr_char(9'(9'h080 + i * 3), 1'b1);
      hold_busy = 1'b0;
      step();
      n_checks++; if (o_start !== 1'b1) begin n_fail++; $display("FAIL rmid_in_start: got %b expected 1", o_start); end
      n_checks++; if (o_level !== 4'd4) begin n_fail++; $display("FAIL rmid_queued: got %0d expected 4", o_level); end
      rst = 1'b1;
      step();
      n_checks++; if (o_start !== 1'b0)    begin n_fail++; $display("FAIL rmid_start: got %b expected 0", o_start); end
      n_checks++; if (o_empty !== 1'b1)    begin n_fail++; $display("FAIL rmid_empty: got %b expected 1", o_empty); end
      n_checks++; if (o_level !== 4'd0)    begin n_fail++; $display("FAIL rmid_level: got %0d expected 0", o_level); end
      n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_ovf: got %b expected 0", o_overflow); end
      n_checks++; if (o_idle !== 1'b1)     begin n_fail++; $display("FAIL rmid_idle: got %b expected 1", o_idle); end
      rst = 1'b0;
      base = start_rises;
      e0 = exp_q[0];
      exp_q.delete();
      exp_q.push_back(e0);
      hi = 0;
      for (int k = 0; k < 30; k++) begin step(); if (o_start === 1'b1) hi++; end
      n_checks++; if (hi != 0) begin n_fail++; $display("FAIL rmid_no_start: got %0d start cycles expected 0", hi); end
      n_checks++; if (start_rises != base) begin n_fail++; $display("FAIL rmid_frames: got %0d expected 0", start_rises - base); end
      check_sb("rmid");
   endtask

   initial begin
      test_reset();
      test_baud();
      test_div_edges();
      test_single();
      test_back_to_back();
      test_overflow();
      test_full_wr_pop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
